// File: rtl/seq_detector.sv
// Serial pattern detector: matches a programmable LEN-bit pattern on w, overlapping or not,
// with a saturating match counter. Define SEQ_DET_STICKY_EN to add the sticky 'hit' output.
module seq_detector #(
    parameter int             LEN     = 3,
    parameter logic [LEN-1:0] PAT_RST = LEN'(3'b101),
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             w,
    input  logic             overlap,
    input  logic             pat_ld,
    input  logic [LEN-1:0]   pat_in,
    input  logic             cnt_clr,
`ifdef SEQ_DET_STICKY_EN
    output logic             hit,
`endif
    output logic             z,
    output logic             z_q,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int            FW       = $clog2(LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(LEN - 1);

    logic [LEN-2:0] hist;
    logic [FW-1:0]  fill;
    logic [LEN-1:0] pat;
    logic [LEN-1:0] window;
    logic           m;

    // The newest bit joins the history on the right, so window lines up with pat bit order.
    assign window = {hist, w};

    // fill is forced to 0 by reset and LEN >= 2, so m (and z) are 0 while rst is low.
    assign m = en & ~pat_ld & (fill == FILL_MAX) & (window == pat);
    assign z = m;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
            pat  <= PAT_RST;
        end else if (pat_ld) begin
            pat  <= pat_in;
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= window[LEN-2:0];
            if (m && !overlap) begin
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt <= '0;
            z_q       <= 1'b0;
        end else begin
            z_q <= m;
            if (cnt_clr) begin
                match_cnt <= '0;
            end else if (m && (match_cnt != '1)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SEQ_DET_STICKY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit <= 1'b0;
        end else if (cnt_clr) begin
            hit <= 1'b0;
        end else if (m) begin
            hit <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed self-checking bench for seq_detector; a second instance with CNT_W=2 covers saturation.
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       w = 1'b0;
    logic       overlap = 1'b1;
    logic       pat_ld = 1'b0;
    logic [2:0] pat_in = 3'b000;
    logic       cnt_clr = 1'b0;

    logic       z, z_q, s_z, s_z_q;
    logic [7:0] match_cnt;
    logic [1:0] s_match_cnt;
`ifdef SEQ_DET_STICKY_EN
    logic       hit, s_hit;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_detector u_dut (
        .clk(clk), .rst(rst), .en(en), .w(w), .overlap(overlap),
        .pat_ld(pat_ld), .pat_in(pat_in), .cnt_clr(cnt_clr),
`ifdef SEQ_DET_STICKY_EN
        .hit(hit),
`endif
        .z(z), .z_q(z_q), .match_cnt(match_cnt)
    );

    seq_detector #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .w(w), .overlap(overlap),
        .pat_ld(pat_ld), .pat_in(pat_in), .cnt_clr(cnt_clr),
`ifdef SEQ_DET_STICKY_EN
        .hit(s_hit),
`endif
        .z(s_z), .z_q(s_z_q), .match_cnt(s_match_cnt)
    );

    // Drives one cycle starting 1 time unit after a rising edge; samples z and z_q mid-cycle.
    task automatic cycle(input logic e, input logic wb, output logic zs, output logic zqs);
        en = e;
        w  = wb;
        #2;
        zs  = z;
        zqs = z_q;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        en = 1'b0; w = 1'b0; pat_ld = 1'b0; cnt_clr = 1'b0; overlap = 1'b1;
        #3;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++;
        if ({z, z_q, match_cnt} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs got z=%b z_q=%b cnt=%0d exp all 0", z, z_q, match_cnt);
        end
`ifdef SEQ_DET_STICKY_EN
        checks++;
        if (hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_hit got=%b exp=0", hit);
        end
`endif
        apply_reset();
    endtask

    task automatic test_overlap();
        logic [0:5] w_seq  = 6'b101010;
        logic [0:5] e_seq  = 6'b111110;
        logic [0:5] exp_z  = 6'b001010;
        logic [0:5] exp_zq = 6'b000101;
        logic zs, zqs;
        apply_reset();
        overlap = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(e_seq[i], w_seq[i], zs, zqs);
            checks++;
            if (zs !== exp_z[i] || zqs !== exp_zq[i]) begin
                errors++;
                $display("FAIL overlap cyc%0d got z=%b z_q=%b exp z=%b z_q=%b",
                         i + 1, zs, zqs, exp_z[i], exp_zq[i]);
            end
        end
        checks++;
        if (match_cnt !== 8'd2) begin
            errors++;
            $display("FAIL overlap_cnt got=%0d exp=2", match_cnt);
        end
    endtask

    task automatic test_non_overlap();
        logic [0:6] w_seq = 7'b1010101;
        logic [0:6] exp_z = 7'b0010001;
        logic zs, zqs;
        apply_reset();
        overlap = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, w_seq[i], zs, zqs);
            checks++;
            if (zs !== exp_z[i]) begin
                errors++;
                $display("FAIL nonoverlap_z cyc%0d got=%b exp=%b", i + 1, zs, exp_z[i]);
            end
            if (i == 4) begin
                checks++;
                if (match_cnt !== 8'd1) begin
                    errors++;
                    $display("FAIL nonoverlap_cnt5 got=%0d exp=1", match_cnt);
                end
            end
        end
        checks++;
        if (match_cnt !== 8'd2) begin
            errors++;
            $display("FAIL nonoverlap_cnt7 got=%0d exp=2", match_cnt);
        end
    endtask

    task automatic test_enable();
        logic [0:5] e_seq = 6'b110001;
        logic [0:5] w_seq = 6'b101011;
        logic [0:5] exp_z = 6'b000001;
        logic zs, zqs;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(e_seq[i], w_seq[i], zs, zqs);
            checks++;
            if (zs !== exp_z[i]) begin
                errors++;
                $display("FAIL enable_z cyc%0d got=%b exp=%b", i + 1, zs, exp_z[i]);
            end
        end
        checks++;
        if (match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL enable_cnt got=%0d exp=1", match_cnt);
        end
    endtask

    task automatic test_pat_load();
        logic [0:4] w_seq = 5'b10110;
        logic [0:4] exp_z = 5'b00001;
        logic zs, zqs;
        apply_reset();
        cycle(1'b1, 1'b1, zs, zqs);
        cycle(1'b1, 1'b0, zs, zqs);
        // Without the load this bit would complete 101 on the stale history.
        pat_ld = 1'b1;
        pat_in = 3'b110;
        cycle(1'b1, 1'b1, zs, zqs);
        pat_ld = 1'b0;
        checks++;
        if (zs !== 1'b0) begin
            errors++;
            $display("FAIL patld_z got=%b exp=0", zs);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, w_seq[i], zs, zqs);
            checks++;
            if (zs !== exp_z[i]) begin
                errors++;
                $display("FAIL patld_stream cyc%0d got=%b exp=%b", i + 1, zs, exp_z[i]);
            end
        end
        checks++;
        if (match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL patld_cnt got=%0d exp=1", match_cnt);
        end
    endtask

    task automatic test_saturate_clear();
        logic zs, zqs;
        apply_reset();
        overlap = 1'b1;
        // 1,0,1,0,...,1 (11 bits) gives five overlapping matches of 101.
        for (int i = 0; i < 11; i++) cycle(1'b1, (i % 2 == 0), zs, zqs);
        checks++;
        if (s_match_cnt !== 2'd3 || match_cnt !== 8'd5) begin
            errors++;
            $display("FAIL sat_cnt got sat=%0d wide=%0d exp sat=3 wide=5", s_match_cnt, match_cnt);
        end
`ifdef SEQ_DET_STICKY_EN
        checks++;
        if (hit !== 1'b1 || s_hit !== 1'b1) begin
            errors++;
            $display("FAIL hit_set got=%b/%b exp=1/1", hit, s_hit);
        end
`endif
        cycle(1'b1, 1'b0, zs, zqs);
        cnt_clr = 1'b1;
        cycle(1'b1, 1'b1, zs, zqs);
        cnt_clr = 1'b0;
        checks++;
        if (zs !== 1'b1) begin
            errors++;
            $display("FAIL clr_match_z got=%b exp=1", zs);
        end
        checks++;
        if (s_match_cnt !== 2'd0 || match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_cnt got sat=%0d wide=%0d exp 0/0", s_match_cnt, match_cnt);
        end
`ifdef SEQ_DET_STICKY_EN
        checks++;
        if (hit !== 1'b0 || s_hit !== 1'b0) begin
            errors++;
            $display("FAIL hit_clr got=%b/%b exp=0/0", hit, s_hit);
        end
`endif
    endtask

    task automatic test_async_reset();
        logic [0:2] w_seq = 3'b101;
        logic [0:2] exp_z = 3'b001;
        logic zs, zqs;
        apply_reset();
        overlap = 1'b1;
        cycle(1'b1, 1'b1, zs, zqs);
        cycle(1'b1, 1'b0, zs, zqs);
        cycle(1'b1, 1'b1, zs, zqs);
        cycle(1'b1, 1'b1, zs, zqs);
        cycle(1'b1, 1'b0, zs, zqs);
        // History is now 1,0; w=1 completes the pattern until reset lands mid-cycle.
        en = 1'b1;
        w  = 1'b1;
        #1;
        checks++;
        if (z !== 1'b1 || match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL pre_reset got z=%b cnt=%0d exp z=1 cnt=1", z, match_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({z, z_q, match_cnt} !== 10'd0) begin
            errors++;
            $display("FAIL async_reset got z=%b z_q=%b cnt=%0d exp all 0", z, z_q, match_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, w_seq[i], zs, zqs);
            checks++;
            if (zs !== exp_z[i]) begin
                errors++;
                $display("FAIL post_reset_z cyc%0d got=%b exp=%b", i + 1, zs, exp_z[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_enable();
        test_pat_load();
        test_saturate_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
Name: seq_detector

Overview:
Parametrised successor to the two-state "w high on consecutive clocks" FSM. Detects a programmable serial bit pattern of LEN bits on input w and supports overlapping and non-overlapping detection. Adds a sample enable and a saturating match counter. Sits between a serial input sampler and control logic that consumes the Mealy match pulse z or its registered copy z_q.

Parameters:
LEN, 3, pattern length in bits (2..16)
PAT_RST, 3'b101 (LEN bits), pattern register value after reset
CNT_W, 8, match counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
en  in  1  sample enable; w is consumed only when en=1
w  in  1  serial data bit
overlap  in  1  1 = overlapping detection, 0 = non-overlapping
pat_ld  in  1  load pat_in into pattern register
pat_in  in  LEN  new pattern; bit LEN-1 is the oldest bit, bit 0 is the newest
cnt_clr  in  1  synchronous clear of match_cnt
z  out  1  Mealy match: combinational from current w and state
z_q  out  1  z registered, one clk later
match_cnt  out  CNT_W  saturating count of matches

Behaviour:
- Reset (rst=0, asynchronous):
  - hist=0, fill=0, pat=PAT_RST, match_cnt=0, z_q=0.
  - z=0 while rst=0.
- State:
  - hist: LEN-1 previous accepted bits.
  - fill: count of accepted bits since last restart, saturating at LEN-1.
- Match term: m = en & ~pat_ld & (fill == LEN-1) & ({hist, w} == pat).
- z = m. It is combinational with zero latency, as in the predecessor.
- Each clk edge with en=1 and pat_ld=0:
  - hist shifts left with w entering at bit 0.
  - fill increments, saturating at LEN-1.
  - If m=1 and overlap=0, fill is set to 0 instead, so the next match needs LEN fresh bits.
  - If m=1 and overlap=1, fill stays LEN-1.
- en=0: hist, fill and pat hold; z=0.
- pat_ld=1, which has priority over en:
  - pat<=pat_in, hist<=0, fill<=0.
  - The w sample that cycle is discarded and z=0.
- match_cnt:
  - On a clk edge with m=1, it increments.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr=1 forces 0 and wins over a simultaneous match.
- z_q <= m each clk edge.
- Changing overlap mid-stream takes effect at the next clk edge; it does not flush history.
- Reset asserted mid-pattern: partial history is lost; detection restarts from fill=0 after release.

Optional Feature:
SEQ_DET_STICKY_EN
- Defined:
  - Adds output port hit (1 bit), reset to 0.
  - hit is set on any clk edge with m=1 and stays set until cnt_clr=1 or reset.
  - cnt_clr together with a match clears hit.
- Undefined:
  - The hit port and its register do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset, defaults (LEN=3, PAT_RST=101), overlap=1, en=1, w=1,0,1,0,1 on cycles 1-5 -> z=1 during cycles 3 and 5 only; z_q=1 in cycles 4 and 6; match_cnt=2.
- Same stream with overlap=0 -> z=1 in cycle 3 only; match_cnt=1. A further w=0,1 in cycles 6-7 gives z=1 in cycle 7; match_cnt=2.
- w=1,0 in cycles 1-2, then en=0 for 3 cycles with w toggling, then en=1 with w=1 -> z=0 while en=0; z=1 on the first enabled w=1; match_cnt=1.
- pat_ld=1 with pat_in=3'b110 after bits 1,0 are shifted in, then w=1,0,1,1,0 -> no match on the stale history; z=1 only on the final bit (last three bits 1,1,0); match_cnt=1.
- Force CNT_W=2 and produce 5 overlapping matches -> match_cnt holds at 3. Then cnt_clr on the same cycle as a match -> match_cnt=0 (and hit=0 with SEQ_DET_STICKY_EN).
- Pull rst low asynchronously mid-cycle after 2 pattern bits -> all outputs 0 immediately. After release, the third bit does not match; the full 3-bit pattern is needed.
